sprite_line_buffer: RTL and testbench

- Double-buffered sprite line buffer. Sits directly downstream of the video timing generator and consumes its hc/hbl/vbl outputs at the pixel-enable rate.
- The sprite renderer writes pixels for the next line into the render bank. The display bank is read at hc, and each location is cleared as it is read.
- Banks swap at each rising edge of hbl. Writes use first-opaque-wins priority via a 2-stage read-modify-write pipeline.

---
 rtl/sprite_line_buffer.sv | 119 +++++++++++
 tb/tb_sprite_line_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer.
// The renderer fills the render bank through a 2-stage read-modify-write
// pipeline (first opaque pixel wins); the display bank is read at hc and
// cleared behind the beam. Banks swap on each rising edge of hbl, once the
// write pipeline has drained.
module sprite_line_buffer #(
  parameter int DW     = 12,
  parameter int LINE_W = 320
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_pix,
  input  logic [8:0]    hc,
  input  logic          hbl,
  input  logic          vbl,
  input  logic          wr_en,
  input  logic [8:0]    wr_x,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          line_start,
  output logic [DW-1:0] pix_data,
  output logic          pix_opaque
);

  localparam int             AW     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [9:0]     LW     = 10'(LINE_W);
  localparam logic [DW-1:0]  TRANSP = {{(DW-4){1'b0}}, 4'hF};

  // Stage-1 entry: target x, pixel, and whether the existing pixel is opaque
  typedef struct packed {
    logic [AW-1:0] x;
    logic [DW-1:0] data;
    logic          old_opq;
  } wr_req_t;

  logic [DW-1:0] mem [2][LINE_W];

  logic          bank_sel, swap_req, hbl_q, s1_vld;
  wr_req_t       s1;
  logic [1:0]    warm_cnt;

  logic          wr_acc, wr_keep, s2_commit, rd_en, hbl_rise, swap_go, warm_done;
  logic          rd_old_opq, fwd_hit;
  logic [DW-1:0] rd_pix;

  assign wr_acc     = wr_en & wr_ready;
  // Out-of-range and transparent writes are acknowledged but never enter the pipe
  assign wr_keep    = wr_acc & ({1'b0, wr_x} < LW) & (wr_data[3:0] != 4'hF);
  assign s2_commit  = s1_vld & ~s1.old_opq;
  assign rd_en      = clk_pix & ({1'b0, hc} < LW);
  assign hbl_rise   = clk_pix & hbl & ~hbl_q;
  // Swap only with both stages empty so in-flight writes land in the old render bank
  assign swap_go    = swap_req & ~s1_vld & ~wr_acc;
  assign warm_done  = (warm_cnt == 2'd2);

  assign rd_pix     = mem[bank_sel][hc[AW-1:0]];
  assign rd_old_opq = (mem[~bank_sel][wr_x[AW-1:0]][3:0] != 4'hF);
  // RAM is read-first: a stage-2 commit to the same x is not visible yet, so forward it
  assign fwd_hit    = s2_commit & (s1.x == wr_x[AW-1:0]);

  // RAM: clear-behind-read on the display bank, stage-2 commit on the render bank
  always_ff @(posedge clk) begin
    if (rd_en)     mem[bank_sel][hc[AW-1:0]] <= TRANSP;
    if (s2_commit) mem[~bank_sel][s1.x]      <= s1.data;
  end

  // Write pipeline stage 1: capture request and the existing pixel's opacity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= wr_keep;
      if (wr_keep)
        s1 <= '{x: wr_x[AW-1:0], data: wr_data, old_opq: rd_old_opq | fwd_hit};
    end
  end

  // Swap control: hbl edge detect, swap request, bank toggle, warm-up count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hbl_q      <= 1'b0;
      swap_req   <= 1'b0;
      bank_sel   <= 1'b0;
      line_start <= 1'b0;
      wr_ready   <= 1'b1;
      warm_cnt   <= 2'd0;
    end else begin
      if (clk_pix) hbl_q <= hbl;
      line_start <= swap_go;
      if (swap_go) begin
        bank_sel <= ~bank_sel;
        swap_req <= 1'b0;
        if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
      end else if (hbl_rise) begin
        swap_req <= 1'b1;
      end
      // Low from the clk after a rise until the clk after the swap executes
      wr_ready <= ~(swap_req | hbl_rise);
    end
  end

  // Display output: registered pixel, masked by blanking and warm-up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_data   <= TRANSP;
      pix_opaque <= 1'b0;
    end else if (clk_pix) begin
      if (rd_en) begin
        pix_data   <= rd_pix;
        pix_opaque <= (rd_pix[3:0] != 4'hF) & ~hbl & ~vbl & warm_done;
      end else begin
        pix_data   <= TRANSP;
        pix_opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: warm-up masking, write priority,
// drop rules, swap/drain ordering and asynchronous reset.
module tb_sprite_line_buffer;
  localparam int DW = 12;
  localparam int LW = 320;
  localparam int NS = LW + 4;
  localparam logic [DW-1:0] TR = 12'h00F;

  logic          clk = 1'b0, reset_n = 1'b0, clk_pix = 1'b0;
  logic          hbl = 1'b0, vbl = 1'b0, wr_en = 1'b0;
  logic [8:0]    hc = '0, wr_x = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, line_start, pix_opaque;
  logic [DW-1:0] pix_data;

  int checks = 0, failures = 0;
  logic [DW-1:0] got_d [NS];
  logic          got_o [NS];
  int            opq_cnt;

  sprite_line_buffer #(.DW(DW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .clk_pix(clk_pix), .hc(hc), .hbl(hbl), .vbl(vbl),
    .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data), .wr_ready(wr_ready),
    .line_start(line_start), .pix_data(pix_data), .pix_opaque(pix_opaque)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One pixel strobe (one clk high), sample the registered output afterwards
  task automatic pix_step(input logic [8:0] h, input logic b,
                          output logic [DW-1:0] d, output logic o);
    @(negedge clk); clk_pix = 1'b1; hc = h; hbl = b;
    @(negedge clk); clk_pix = 1'b0; d = pix_data; o = pix_opaque;
  endtask

  task automatic scan();
    logic [DW-1:0] d;
    logic o;
    opq_cnt = 0;
    for (int x = 0; x < NS; x++) begin
      pix_step(9'(x), 1'b0, d, o);
      got_d[x] = d; got_o[x] = o;
      if (o) opq_cnt++;
    end
  endtask

  task automatic swap(input string tag);
    logic [DW-1:0] d;
    logic o, seen;
    pix_step(9'd400, 1'b1, d, o);
    chk({tag, "_rdy0"}, 32'(wr_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk); seen = line_start;
    end
    chk({tag, "_ls"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_ls_pulse"}, 32'(line_start), 32'd0);
    pix_step(9'd400, 1'b0, d, o);
  endtask

  task automatic wr(input logic [8:0] x, input logic [DW-1:0] d);
    @(negedge clk); wr_en = 1'b1; wr_x = x; wr_data = d;
    for (int i = 0; i < 16 && !wr_ready; i++) @(negedge clk);
    chk("wr_ack", 32'(wr_ready), 32'd1);
  endtask

  task automatic wr_idle();
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 32'(wr_ready),   32'd1);
    chk({tag, "_ls"},  32'(line_start), 32'd0);
    chk({tag, "_pd"},  32'(pix_data),   32'(TR));
    chk({tag, "_po"},  32'(pix_opaque), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic o;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    @(negedge clk); reset_n = 1'b1;

    // Warm-up: each line scanned clears a bank; opaque stays masked
    scan();        chk("warm0_opq", 32'(opq_cnt), 32'd0);
    swap("s1"); scan(); chk("warm1_opq", 32'(opq_cnt), 32'd0);
    swap("s2"); scan(); chk("warm2_opq", 32'(opq_cnt), 32'd0);

    // Basic write, latency and clear
    wr(9'd5, 12'h123); wr_idle();
    swap("s3"); scan();
    chk("x5_d", 32'(got_d[5]), 32'h123);
    chk("x5_o", 32'(got_o[5]), 32'd1);
    chk("x4_d", 32'(got_d[4]), 32'(TR));
    chk("oob_d", 32'(got_d[LW]), 32'(TR));
    chk("oob_o", 32'(got_o[LW]), 32'd0);

    // First-wins with forwarding; dropped writes still acknowledged
    wr(9'd10, 12'h041); wr(9'd10, 12'h072); wr(9'd320, 12'h0AA); wr(9'd20, 12'h00F);
    wr_idle();
    swap("s4"); scan();
    chk("x10_d", 32'(got_d[10]), 32'h041);
    chk("x10_o", 32'(got_o[10]), 32'd1);
    chk("x20_d", 32'(got_d[20]), 32'(TR));
    chk("x20_o", 32'(got_o[20]), 32'd0);
    chk("x0_d",  32'(got_d[0]),  32'(TR));
    chk("s4_opq", 32'(opq_cnt), 32'd1);

    // x=5 was cleared when read on the earlier line
    swap("s5"); scan();
    chk("x5clr_d", 32'(got_d[5]), 32'(TR));
    chk("x5clr_o", 32'(got_o[5]), 32'd0);

    // Accept and hbl rise in the same clk: swap waits for the pipe to drain
    @(negedge clk); wr_en = 1'b1; wr_x = 9'd30; wr_data = 12'h0A5;
    clk_pix = 1'b1; hc = 9'd400; hbl = 1'b1;
    @(negedge clk); clk_pix = 1'b0; wr_x = 9'd31; wr_data = 12'h0B6;
    chk("hold_rdy0", 32'(wr_ready), 32'd0);
    chk("hold_ls1",  32'(line_start), 32'd0);
    @(negedge clk); chk("hold_ls2", 32'(line_start), 32'd0);
    @(negedge clk); chk("hold_ls3", 32'(line_start), 32'd1);
    @(negedge clk); chk("hold_rdy1", 32'(wr_ready), 32'd1);
    @(negedge clk); wr_en = 1'b0;
    pix_step(9'd400, 1'b0, d, o);
    scan();
    chk("x30_d", 32'(got_d[30]), 32'h0A5);
    chk("x30_o", 32'(got_o[30]), 32'd1);
    chk("x31_d", 32'(got_d[31]), 32'(TR));
    swap("s7"); scan();
    chk("x31n_d", 32'(got_d[31]), 32'h0B6);
    chk("x31n_o", 32'(got_o[31]), 32'd1);

    // Asynchronous reset mid-line with a write and a swap request in flight
    wr(9'd40, 12'h0C3); wr(9'd41, 12'h0D4); wr_idle();
    swap("s8");
    pix_step(9'd40, 1'b0, d, o);
    chk("pre_d40", 32'(d), 32'h0C3);
    chk("pre_o40", 32'(o), 32'd1);
    @(negedge clk); clk_pix = 1'b1; hc = 9'd41; hbl = 1'b1;
    wr_en = 1'b1; wr_x = 9'd50; wr_data = 12'h0E7;
    @(posedge clk); #2;
    chk("pre_d41",  32'(pix_data), 32'h0D4);
    chk("pre_blnk", 32'(pix_opaque), 32'd0);
    chk("pre_rdy",  32'(wr_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk_rst("midrst");
    @(negedge clk); clk_pix = 1'b0; wr_en = 1'b0; hbl = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    wr(9'd60, 12'h0E5); wr_idle();
    swap("r1"); scan();
    chk("r1_x60_d", 32'(got_d[60]), 32'h0E5);
    chk("r1_x60_o", 32'(got_o[60]), 32'd0);
    chk("r1_x50_d", 32'(got_d[50]), 32'(TR));
    swap("r2");
    wr(9'd70, 12'h0A6); wr_idle();
    swap("r3"); scan();
    chk("r3_x70_d", 32'(got_d[70]), 32'h0A6);
    chk("r3_x70_o", 32'(got_o[70]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
